// File: rtl/cpu_ctrl_hs_pkg.sv
// Shared definitions for the multi-cycle CPU controller: memory command codes,
// instruction opcode/op fields, register/writeback select codes, controller
// state encoding and the packed control-output bundle.
// Optional feature macro: CTRL_BRANCH_EN adds the BR state.
package cpu_ctrl_hs_pkg;

    localparam int unsigned STATE_W = 5;

    // mem_cmd encodings
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b11;

    // opcode field IR[15:13]
    localparam logic [2:0] OPC_BR   = 3'b001;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // op field IR[12:11]
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ALU_CMP = 2'b01;
    localparam logic [1:0] OP_ALU_MVN = 2'b11;

    // register-file read/write select
    localparam logic [1:0] NSEL_RN = 2'b00;
    localparam logic [1:0] NSEL_RD = 2'b01;
    localparam logic [1:0] NSEL_RM = 2'b11;

    // writeback source select
    localparam logic [1:0] VSEL_MDATA  = 2'b00;
    localparam logic [1:0] VSEL_SXIMM8 = 2'b01;
    localparam logic [1:0] VSEL_C      = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        S_RST     = 5'd0,
        S_IF_REQ  = 5'd1,
        S_IF_LD   = 5'd2,
        S_PC_INC  = 5'd3,
        S_DECODE  = 5'd4,
        S_MOV_IM  = 5'd5,
        S_LD_A    = 5'd6,
        S_LD_B    = 5'd7,
        S_EXE     = 5'd8,
        S_WB      = 5'd9,
        S_ADDR_C  = 5'd10,
        S_ADDR_LD = 5'd11,
        S_MEM_RD  = 5'd12,
        S_LDR_WB  = 5'd13,
        S_ST_B    = 5'd14,
        S_ST_C    = 5'd15,
        S_MEM_WR  = 5'd16,
        S_HALT    = 5'd17,
`ifdef CTRL_BRANCH_EN
        S_BR      = 5'd19,
`endif
        S_ERR     = 5'd18
    } state_t;

    typedef struct packed {
        logic [1:0] mem_cmd;
        logic       addr_sel;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       load_addr;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       write;
        logic [1:0] nsel;
        logic [1:0] vsel;
        logic       pc_sel;
        logic       halted;
        logic       mem_err;
    } ctrl_t;

    // States in which the controller waits on mem_ack
    function automatic logic is_wait_state(input state_t s);
        return (s == S_IF_REQ) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/cpu_ctrl_hs_mem_wait.sv
// Memory-handshake wait counter with timeout detection.
// Ports: clk, reset (async active-low), start (clear on wait-state entry),
//        ack (mem_ack), timeout (count reached WAIT_MAX with ack low).
module cpu_mem_wait #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic ack,
    output logic timeout
);

    logic [WAIT_W-1:0] cnt_q;

    // Counts cycles spent without ack; cleared on entry to a wait state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (!ack) begin
            cnt_q <= cnt_q + WAIT_W'(1);
        end
    end

    // ack in the limit cycle still completes the access
    assign timeout = (WAIT_MAX != 0) && (cnt_q == WAIT_W'(WAIT_MAX)) && !ack;

endmodule

// File: rtl/cpu_ctrl_hs.sv
// Multi-cycle controller for the simple RISC datapath: fetch/decode/execute of
// MOV, ALU, LDR, STR, HALT with a bounded mem_ack handshake on RAM accesses.
// Ports: clk, reset (async active-low); opcode/op/cond from IR; flags {N,V,Z};
//        mem_ack from RAM; mem_cmd/addr_sel to RAM; datapath load/select
//        strobes; halted and sticky mem_err status.
// Optional feature macro: CTRL_BRANCH_EN (opcode 001 conditional branch).
// Outputs are registered from the next state, so they always reflect the
// current state and jump to the RST values as soon as reset falls.
module cpu_ctrl_hs
    import cpu_ctrl_hs_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    input  logic       mem_ack,
    output logic [1:0] mem_cmd,
    output logic       addr_sel,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       load_addr,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       write,
    output logic [1:0] nsel,
    output logic [1:0] vsel,
    output logic       pc_sel,
    output logic       halted,
    output logic       mem_err
);

    state_t st_q, st_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   wait_start;
    logic   timeout;
    logic   take_br;

`ifdef CTRL_BRANCH_EN
    logic f_n, f_v, f_z;
    assign {f_n, f_v, f_z} = flags;

    // Branch condition evaluation
    always_comb begin
        take_br = 1'b0;
        case (cond)
            3'b000:  take_br = 1'b1;
            3'b001:  take_br = f_z;
            3'b010:  take_br = !f_z;
            3'b011:  take_br = f_n ^ f_v;
            3'b100:  take_br = (f_n ^ f_v) | f_z;
            default: take_br = 1'b0;
        endcase
    end
`else
    logic unused_br;
    assign unused_br = ^{cond, flags};
    assign take_br   = 1'b0;
`endif

    // Wait counter clears whenever a wait state is freshly entered
    assign wait_start = is_wait_state(st_d) && (st_d != st_q);

    cpu_mem_wait #(
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (WAIT_W)
    ) u_mem_wait (
        .clk     (clk),
        .reset   (reset),
        .start   (wait_start),
        .ack     (mem_ack),
        .timeout (timeout)
    );

    // Next-state logic
    always_comb begin
        st_d = st_q;
        case (st_q)
            S_RST:    st_d = S_IF_REQ;
            S_IF_REQ: begin
                if (mem_ack)      st_d = S_IF_LD;
                else if (timeout) st_d = S_ERR;
            end
            S_IF_LD:  st_d = S_PC_INC;
            S_PC_INC: st_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OPC_MOV: begin
                        if (op == OP_MOV_IMM)      st_d = S_MOV_IM;
                        else if (op == OP_MOV_REG) st_d = S_LD_B;
                        else                       st_d = S_IF_REQ;
                    end
                    OPC_ALU:  st_d = (op == OP_ALU_MVN) ? S_LD_B : S_LD_A;
                    OPC_LDR,
                    OPC_STR:  st_d = S_LD_A;
                    OPC_HALT: st_d = S_HALT;
`ifdef CTRL_BRANCH_EN
                    OPC_BR:   st_d = S_BR;
`endif
                    default:  st_d = S_IF_REQ;
                endcase
            end
            S_MOV_IM: st_d = S_IF_REQ;
            S_LD_A:   st_d = (opcode == OPC_LDR || opcode == OPC_STR) ? S_ADDR_C : S_LD_B;
            S_LD_B:   st_d = S_EXE;
            S_EXE:    st_d = (opcode == OPC_ALU && op == OP_ALU_CMP) ? S_IF_REQ : S_WB;
            S_WB:     st_d = S_IF_REQ;
            S_ADDR_C: st_d = S_ADDR_LD;
            S_ADDR_LD: st_d = (opcode == OPC_LDR) ? S_MEM_RD : S_ST_B;
            S_MEM_RD: begin
                if (mem_ack)      st_d = S_LDR_WB;
                else if (timeout) st_d = S_ERR;
            end
            S_LDR_WB: st_d = S_IF_REQ;
            S_ST_B:   st_d = S_ST_C;
            S_ST_C:   st_d = S_MEM_WR;
            S_MEM_WR: begin
                if (mem_ack)      st_d = S_IF_REQ;
                else if (timeout) st_d = S_ERR;
            end
            S_HALT:   st_d = S_HALT;
            S_ERR:    st_d = S_ERR;
`ifdef CTRL_BRANCH_EN
            S_BR:     st_d = S_IF_REQ;
`endif
            default:  st_d = S_RST;
        endcase
    end

    // Output decode for the state being entered
    always_comb begin
        ctrl_d = '0;
        case (st_d)
            S_RST: begin
                ctrl_d.reset_pc = 1'b1;
                ctrl_d.load_pc  = 1'b1;
            end
            S_IF_REQ: begin
                ctrl_d.mem_cmd  = MEM_READ;
                ctrl_d.addr_sel = 1'b1;
            end
            S_IF_LD:  ctrl_d.load_ir = 1'b1;
            S_PC_INC: ctrl_d.load_pc = 1'b1;
            S_MOV_IM: begin
                ctrl_d.nsel  = NSEL_RN;
                ctrl_d.vsel  = VSEL_SXIMM8;
                ctrl_d.write = 1'b1;
            end
            S_LD_A: begin
                ctrl_d.nsel  = NSEL_RN;
                ctrl_d.loada = 1'b1;
            end
            S_LD_B: begin
                ctrl_d.nsel  = NSEL_RM;
                ctrl_d.loadb = 1'b1;
            end
            S_EXE: begin
                // single-operand instructions zero the A input
                ctrl_d.asel = (opcode == OPC_MOV && op == OP_MOV_REG) ||
                              (opcode == OPC_ALU && op == OP_ALU_MVN);
                if (opcode == OPC_ALU && op == OP_ALU_CMP) ctrl_d.loads = 1'b1;
                else                                       ctrl_d.loadc = 1'b1;
            end
            S_WB: begin
                ctrl_d.nsel  = NSEL_RD;
                ctrl_d.vsel  = VSEL_C;
                ctrl_d.write = 1'b1;
            end
            S_ADDR_C: begin
                ctrl_d.bsel  = 1'b1;
                ctrl_d.loadc = 1'b1;
            end
            S_ADDR_LD: ctrl_d.load_addr = 1'b1;
            S_MEM_RD:  ctrl_d.mem_cmd   = MEM_READ;
            S_LDR_WB: begin
                ctrl_d.nsel  = NSEL_RD;
                ctrl_d.vsel  = VSEL_MDATA;
                ctrl_d.write = 1'b1;
            end
            S_ST_B: begin
                ctrl_d.nsel  = NSEL_RD;
                ctrl_d.loadb = 1'b1;
            end
            S_ST_C: begin
                ctrl_d.asel  = 1'b1;
                ctrl_d.loadc = 1'b1;
            end
            S_MEM_WR: ctrl_d.mem_cmd = MEM_WRITE;
            S_HALT:   ctrl_d.halted  = 1'b1;
            S_ERR:    ctrl_d.mem_err = 1'b1;
`ifdef CTRL_BRANCH_EN
            S_BR: begin
                // condition sampled on the DECODE->BR transition
                ctrl_d.pc_sel  = take_br;
                ctrl_d.load_pc = take_br;
            end
`endif
            default: ctrl_d = '0;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q            <= S_RST;
            ctrl_q          <= '0;
            ctrl_q.reset_pc <= 1'b1;
            ctrl_q.load_pc  <= 1'b1;
        end else begin
            st_q   <= st_d;
            ctrl_q <= ctrl_d;
        end
    end

    assign mem_cmd   = ctrl_q.mem_cmd;
    assign addr_sel  = ctrl_q.addr_sel;
    assign load_ir   = ctrl_q.load_ir;
    assign load_pc   = ctrl_q.load_pc;
    assign reset_pc  = ctrl_q.reset_pc;
    assign load_addr = ctrl_q.load_addr;
    assign loada     = ctrl_q.loada;
    assign loadb     = ctrl_q.loadb;
    assign loadc     = ctrl_q.loadc;
    assign loads     = ctrl_q.loads;
    assign asel      = ctrl_q.asel;
    assign bsel      = ctrl_q.bsel;
    assign write     = ctrl_q.write;
    assign nsel      = ctrl_q.nsel;
    assign vsel      = ctrl_q.vsel;
    assign pc_sel    = ctrl_q.pc_sel;
    assign halted    = ctrl_q.halted;
    assign mem_err   = ctrl_q.mem_err;

endmodule

// File: tb/tb_cpu_ctrl_hs.sv
// Scoreboard bench for cpu_ctrl_hs (WAIT_MAX=4). The driver pushes the expected
// output vector for each cycle it drives; a negedge monitor pops and compares.
module tb_cpu_ctrl_hs;

    typedef struct packed {
        logic [1:0] mem_cmd;
        logic       addr_sel, load_ir, load_pc, reset_pc, load_addr;
        logic       loada, loadb, loadc, loads, asel, bsel, write;
        logic [1:0] nsel;
        logic [1:0] vsel;
        logic       pc_sel, halted, mem_err;
    } obs_t;

    typedef enum int {
        E_RST, E_IFREQ, E_IFLD, E_PCINC, E_DECODE, E_MOVIM, E_LDA, E_LDB,
        E_EXE_CMP, E_EXE_C, E_EXE_AC, E_WB, E_ADDRC, E_ADDRLD, E_MEMRD,
        E_LDRWB, E_STB, E_STC, E_MEMWR, E_HALT, E_ERR, E_BR_T, E_BR_N
    } step_e;

    typedef struct {
        step_e s;
        obs_t  o;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] opcode, cond, flags;
    logic [1:0] op;
    logic       mem_ack;
    logic [1:0] mem_cmd, nsel, vsel;
    logic       addr_sel, load_ir, load_pc, reset_pc, load_addr;
    logic       loada, loadb, loadc, loads, asel, bsel, write;
    logic       pc_sel, halted, mem_err;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    obs_t act;

    always #5 clk = ~clk;

    cpu_ctrl_hs #(.WAIT_MAX(4), .WAIT_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
        .flags(flags), .mem_ack(mem_ack), .mem_cmd(mem_cmd), .addr_sel(addr_sel),
        .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
        .load_addr(load_addr), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .write(write), .nsel(nsel),
        .vsel(vsel), .pc_sel(pc_sel), .halted(halted), .mem_err(mem_err)
    );

    always_comb act = {mem_cmd, addr_sel, load_ir, load_pc, reset_pc, load_addr,
                       loada, loadb, loadc, loads, asel, bsel, write,
                       nsel, vsel, pc_sel, halted, mem_err};

    // Expected outputs for each controller step, written out by hand
    function automatic obs_t exp_of(input step_e s);
        obs_t o = '0;
        case (s)
            E_RST:     begin o.reset_pc = 1; o.load_pc = 1; end
            E_IFREQ:   begin o.mem_cmd = 2'b01; o.addr_sel = 1; end
            E_IFLD:    o.load_ir = 1;
            E_PCINC:   o.load_pc = 1;
            E_DECODE:  o = '0;
            E_MOVIM:   begin o.nsel = 2'b00; o.vsel = 2'b01; o.write = 1; end
            E_LDA:     begin o.nsel = 2'b00; o.loada = 1; end
            E_LDB:     begin o.nsel = 2'b11; o.loadb = 1; end
            E_EXE_CMP: o.loads = 1;
            E_EXE_C:   o.loadc = 1;
            E_EXE_AC:  begin o.asel = 1; o.loadc = 1; end
            E_WB:      begin o.nsel = 2'b01; o.vsel = 2'b11; o.write = 1; end
            E_ADDRC:   begin o.bsel = 1; o.loadc = 1; end
            E_ADDRLD:  o.load_addr = 1;
            E_MEMRD:   begin o.mem_cmd = 2'b01; o.addr_sel = 0; end
            E_LDRWB:   begin o.nsel = 2'b01; o.vsel = 2'b00; o.write = 1; end
            E_STB:     begin o.nsel = 2'b01; o.loadb = 1; end
            E_STC:     begin o.asel = 1; o.loadc = 1; end
            E_MEMWR:   begin o.mem_cmd = 2'b11; o.addr_sel = 0; end
            E_HALT:    o.halted = 1;
            E_ERR:     o.mem_err = 1;
            E_BR_T:    begin o.pc_sel = 1; o.load_pc = 1; end
            E_BR_N:    o = '0;
            default:   o = '0;
        endcase
        return o;
    endfunction

    // Monitor: compare current DUT outputs against the next expected entry
    always @(negedge clk) begin
        if (q.size() > 0) begin
            ent_t e;
            e = q.pop_front();
            checks++;
            if (act !== e.o) begin
                errors++;
                $display("FAIL %s @%0t: got %h expected %h", e.s.name(), $time, act, e.o);
            end
        end
    end

    // Drive one cycle: set ack, queue this cycle's expected outputs, advance
    task automatic cyc(input step_e s, input logic ack);
        ent_t e;
        mem_ack = ack;
        e.s = s;
        e.o = exp_of(s);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Instruction fetch with `lat` cycles of ack delay, through DECODE
    task automatic fetch(input logic [2:0] opc, input logic [1:0] o2, input int lat);
        opcode = opc;
        op     = o2;
        for (int i = 0; i < lat; i++) cyc(E_IFREQ, 1'b0);
        cyc(E_IFREQ, 1'b1);
        cyc(E_IFLD, 1'b1);
        cyc(E_PCINC, 1'b0);
        cyc(E_DECODE, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; opcode = 3'b000; op = 2'b00; cond = 3'b000;
        flags = 3'b000; mem_ack = 1'b0;
        @(posedge clk); #1;
        cyc(E_RST, 1'b0);
        reset = 1'b1;
        cyc(E_RST, 1'b0);

        // MOV R0,#5 with ack after 3 waiting cycles
        fetch(3'b110, 2'b10, 3);
        cyc(E_MOVIM, 1'b0);
        // CMP: status only, no writeback
        fetch(3'b101, 2'b01, 0);
        cyc(E_LDA, 1'b0); cyc(E_LDB, 1'b0); cyc(E_EXE_CMP, 1'b0);
        // ADD
        fetch(3'b101, 2'b00, 1);
        cyc(E_LDA, 1'b0); cyc(E_LDB, 1'b0); cyc(E_EXE_C, 1'b0); cyc(E_WB, 1'b0);
        // MVN and MOV Rd,Rm skip LD_A and zero A
        fetch(3'b101, 2'b11, 0);
        cyc(E_LDB, 1'b0); cyc(E_EXE_AC, 1'b0); cyc(E_WB, 1'b0);
        fetch(3'b110, 2'b00, 0);
        cyc(E_LDB, 1'b0); cyc(E_EXE_AC, 1'b0); cyc(E_WB, 1'b0);
        // LDR with one wait cycle on the data read
        fetch(3'b011, 2'b00, 0);
        cyc(E_LDA, 1'b0); cyc(E_ADDRC, 1'b0); cyc(E_ADDRLD, 1'b1);
        cyc(E_MEMRD, 1'b0); cyc(E_MEMRD, 1'b1); cyc(E_LDRWB, 1'b0);
        // STR, ack in the first MEM_WR cycle
        fetch(3'b100, 2'b00, 0);
        cyc(E_LDA, 1'b0); cyc(E_ADDRC, 1'b0); cyc(E_ADDRLD, 1'b0);
        cyc(E_STB, 1'b0); cyc(E_STC, 1'b0); cyc(E_MEMWR, 1'b1);
        // Ack arriving in the limit cycle completes the fetch
        fetch(3'b000, 2'b00, 4);
`ifdef CTRL_BRANCH_EN
        // opcode 001: branch on Z
        cond = 3'b001; flags = 3'b001;
        fetch(3'b001, 2'b00, 0);
        cyc(E_BR_T, 1'b0);
        flags = 3'b000;
        fetch(3'b001, 2'b00, 0);
        cyc(E_BR_N, 1'b0);
`else
        // opcode 001 behaves as a NOP
        cond = 3'b001; flags = 3'b001;
        fetch(3'b001, 2'b00, 0);
`endif
        // STR aborted by reset in the middle of MEM_WR
        fetch(3'b100, 2'b00, 0);
        cyc(E_LDA, 1'b0); cyc(E_ADDRC, 1'b0); cyc(E_ADDRLD, 1'b0);
        cyc(E_STB, 1'b0); cyc(E_STC, 1'b0); cyc(E_MEMWR, 1'b0);
        #1 reset = 1'b0;
        cyc(E_RST, 1'b0);
        reset = 1'b1;
        cyc(E_RST, 1'b0);
        // Fetch never acked: five waiting cycles then sticky ERR
        opcode = 3'b000;
        for (int i = 0; i < 5; i++) cyc(E_IFREQ, 1'b0);
        cyc(E_ERR, 1'b1); cyc(E_ERR, 1'b0); cyc(E_ERR, 1'b1);
        reset = 1'b0;
        cyc(E_RST, 1'b0);
        reset = 1'b1;
        cyc(E_RST, 1'b0);
        // HALT is terminal and ignores ack
        fetch(3'b111, 2'b00, 0);
        cyc(E_HALT, 1'b1); cyc(E_HALT, 1'b0); cyc(E_HALT, 1'b1);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
